// File: rtl/rf_ctx_ctrl.sv
// Call/return context sequencer: owns the register-stack pointer and return-PC stack.
// Latency: CALL ack@0, push@1, idle@2; RET ack@0, pop@1, ret_valid@2, idle@3.
// Backpressure: requests are sampled only in IDLE; ctx_busy high means requests are ignored.
module rf_ctx_ctrl #(
    parameter int PC_WIDTH = 5,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ctx_call_req,
    input  logic                ctx_ret_req,
    input  logic [PC_WIDTH-1:0] ctx_ret_pc_in,
    input  logic                ctx_err_clr,
    output logic                ctx_ack,
    output logic                ctx_busy,
    output logic [PC_WIDTH-1:0] ctx_ret_pc_out,
    output logic                ctx_ret_valid,
    output logic                rf_stack_push,
    output logic                rf_stack_pop,
    output logic [PC_WIDTH-1:0] rf_stack_pointer,
    output logic                rf_we_inhibit,
    output logic                ctx_err_ovf,
    output logic                ctx_err_unf
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CALL_PUSH = 2'd1,
        RET_POP   = 2'd2,
        RET_DEC   = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] SP_FULL  = PC_WIDTH'(DEPTH);
    localparam logic [PC_WIDTH-1:0] SP_ONE   = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] SP_EMPTY = '0;
    // Sized to the full pointer range so any sp value indexes it directly; slot 0 is never used.
    localparam int SLOTS = 2 ** PC_WIDTH;

    state_t              state;
    state_t              state_nxt;
    logic [PC_WIDTH-1:0] sp;
    logic [PC_WIDTH-1:0] pcstk [SLOTS];

    // Decoded request outcomes, only meaningful in IDLE.
    logic call_ok;
    logic call_ovf;
    logic ret_ok;
    logic ret_unf;

    assign rf_stack_pointer = sp;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; call wins over ret when both are requested.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (call_ok) begin
                    state_nxt = CALL_PUSH;
                end else if (ret_ok) begin
                    state_nxt = RET_POP;
                end
            end
            CALL_PUSH: state_nxt = IDLE;
            RET_POP:   state_nxt = RET_DEC;
            RET_DEC:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Combinational outputs and request classification decoded from state and inputs.
    always_comb begin
        ctx_busy      = (state != IDLE);
        rf_we_inhibit = (state == CALL_PUSH) || (state == RET_POP);
        ctx_ack       = (state == IDLE) && (ctx_call_req || ctx_ret_req);
        call_ok       = (state == IDLE) && ctx_call_req && (sp < SP_FULL);
        call_ovf      = (state == IDLE) && ctx_call_req && (sp >= SP_FULL);
        ret_ok        = (state == IDLE) && !ctx_call_req && ctx_ret_req && (sp != SP_EMPTY);
        ret_unf       = (state == IDLE) && !ctx_call_req && ctx_ret_req && (sp == SP_EMPTY);
    end

    // Registered pulses, stack pointer, popped PC and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp             <= '0;
            rf_stack_push  <= 1'b0;
            rf_stack_pop   <= 1'b0;
            ctx_ret_valid  <= 1'b0;
            ctx_ret_pc_out <= '0;
            ctx_err_ovf    <= 1'b0;
            ctx_err_unf    <= 1'b0;
        end else begin
            rf_stack_push <= call_ok;
            rf_stack_pop  <= ret_ok;
            ctx_ret_valid <= (state == RET_POP);
            if (call_ok) begin
                sp <= sp + SP_ONE;
            end else if (state == RET_DEC) begin
                sp <= sp - SP_ONE;
            end
            if (state == RET_POP) begin
                ctx_ret_pc_out <= pcstk[sp];
            end
            // A new error in the same cycle as a clear keeps the flag set.
            if (call_ovf) begin
                ctx_err_ovf <= 1'b1;
            end else if (ctx_err_clr) begin
                ctx_err_ovf <= 1'b0;
            end
            if (ret_unf) begin
                ctx_err_unf <= 1'b1;
            end else if (ctx_err_clr) begin
                ctx_err_unf <= 1'b0;
            end
        end
    end

    // Return-PC storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (call_ok) begin
            pcstk[sp + SP_ONE] <= ctx_ret_pc_in;
        end
    end

endmodule

// File: tb/tb_rf_ctx_ctrl.sv
module tb_rf_ctx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ctx_call_req;
    logic       ctx_ret_req;
    logic [4:0] ctx_ret_pc_in;
    logic       ctx_err_clr;
    logic       ctx_ack;
    logic       ctx_busy;
    logic [4:0] ctx_ret_pc_out;
    logic       ctx_ret_valid;
    logic       rf_stack_push;
    logic       rf_stack_pop;
    logic [4:0] rf_stack_pointer;
    logic       rf_we_inhibit;
    logic       ctx_err_ovf;
    logic       ctx_err_unf;

    int checks;
    int errors;

    rf_ctx_ctrl #(.PC_WIDTH(5), .DEPTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ctx_call_req     (ctx_call_req),
        .ctx_ret_req      (ctx_ret_req),
        .ctx_ret_pc_in    (ctx_ret_pc_in),
        .ctx_err_clr      (ctx_err_clr),
        .ctx_ack          (ctx_ack),
        .ctx_busy         (ctx_busy),
        .ctx_ret_pc_out   (ctx_ret_pc_out),
        .ctx_ret_valid    (ctx_ret_valid),
        .rf_stack_push    (rf_stack_push),
        .rf_stack_pop     (rf_stack_pop),
        .rf_stack_pointer (rf_stack_pointer),
        .rf_we_inhibit    (rf_we_inhibit),
        .ctx_err_ovf      (ctx_err_ovf),
        .ctx_err_unf      (ctx_err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read 1ns later, away from the rising edge.

    // One CALL: returns ack at cycle 0, push and sp at cycle 1. Ends in cycle 1.
    task automatic do_call(input logic [4:0] pc, output logic ack_o, output logic push_o,
                           output logic [4:0] sp_o);
        @(negedge clk);
        ctx_call_req = 1'b1; ctx_ret_pc_in = pc;
        #1 ack_o = ctx_ack;
        @(negedge clk);
        ctx_call_req = 1'b0;
        #1 push_o = rf_stack_push; sp_o = rf_stack_pointer;
    endtask

    // One RET: ack at cycle 0, pop and sp at cycle 1, valid and pc at cycle 2. Ends in cycle 2.
    task automatic do_ret(output logic ack_o, output logic pop_o, output logic [4:0] sp_o,
                          output logic valid_o, output logic [4:0] pc_o);
        @(negedge clk);
        ctx_ret_req = 1'b1;
        #1 ack_o = ctx_ack;
        @(negedge clk);
        ctx_ret_req = 1'b0;
        #1 pop_o = rf_stack_pop; sp_o = rf_stack_pointer;
        @(negedge clk);
        #1 valid_o = ctx_ret_valid; pc_o = ctx_ret_pc_out;
    endtask

    task automatic test_reset();
        logic a, p; logic [4:0] s;
        rst_n = 1'b0; ctx_call_req = 1'b0; ctx_ret_req = 1'b0; ctx_ret_pc_in = '0; ctx_err_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({ctx_ack, ctx_busy, ctx_ret_valid, rf_stack_push, rf_stack_pop, rf_we_inhibit, ctx_err_ovf, ctx_err_unf} !== 8'h00) begin errors++; $display("FAIL reset_outputs got %b exp 00000000", {ctx_ack, ctx_busy, ctx_ret_valid, rf_stack_push, rf_stack_pop, rf_we_inhibit, ctx_err_ovf, ctx_err_unf}); end
        checks++; if (rf_stack_pointer !== 5'd0 || ctx_ret_pc_out !== 5'd0) begin errors++; $display("FAIL reset_sp_pc got sp=%0d pc=%0h exp 0 0", rf_stack_pointer, ctx_ret_pc_out); end
        @(negedge clk); rst_n = 1'b1;
        do_call(5'h11, a, p, s);
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL reset_precall_push got %b exp 1", p); end
        rst_n = 1'b0;
        #1;
        checks++; if (rf_stack_push !== 1'b0 || ctx_busy !== 1'b0 || rf_stack_pointer !== 5'd0) begin errors++; $display("FAIL reset_midcall got push=%b busy=%b sp=%0d exp 0 0 0", rf_stack_push, ctx_busy, rf_stack_pointer); end
        checks++; if (ctx_err_ovf !== 1'b0 || ctx_err_unf !== 1'b0) begin errors++; $display("FAIL reset_midcall_flags got %b%b exp 00", ctx_err_ovf, ctx_err_unf); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single_call();
        @(negedge clk);
        ctx_call_req = 1'b1; ctx_ret_pc_in = 5'h0A;
        #1;
        checks++; if (ctx_ack !== 1'b1 || ctx_busy !== 1'b0) begin errors++; $display("FAIL call_c0 got ack=%b busy=%b exp 1 0", ctx_ack, ctx_busy); end
        @(negedge clk);
        ctx_call_req = 1'b0;
        #1;
        checks++; if (rf_stack_push !== 1'b1 || rf_stack_pointer !== 5'd1) begin errors++; $display("FAIL call_c1_push got push=%b sp=%0d exp 1 1", rf_stack_push, rf_stack_pointer); end
        checks++; if (rf_we_inhibit !== 1'b1 || ctx_busy !== 1'b1 || ctx_ack !== 1'b0) begin errors++; $display("FAIL call_c1_ctl got inh=%b busy=%b ack=%b exp 1 1 0", rf_we_inhibit, ctx_busy, ctx_ack); end
        @(negedge clk);
        #1;
        checks++; if (ctx_busy !== 1'b0 || rf_stack_push !== 1'b0 || rf_we_inhibit !== 1'b0) begin errors++; $display("FAIL call_c2 got busy=%b push=%b inh=%b exp 0 0 0", ctx_busy, rf_stack_push, rf_we_inhibit); end
    endtask

    task automatic test_call_ret();
        logic a, p, v; logic [4:0] s, pc;
        do_ret(a, p, s, v, pc);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL ret_ack got %b exp 1", a); end
        checks++; if (p !== 1'b1 || s !== 5'd1) begin errors++; $display("FAIL ret_pop got pop=%b sp=%0d exp 1 1", p, s); end
        checks++; if (v !== 1'b1 || pc !== 5'h0A) begin errors++; $display("FAIL ret_valid got valid=%b pc=%0h exp 1 a", v, pc); end
        @(negedge clk);
        #1;
        checks++; if (rf_stack_pointer !== 5'd0 || ctx_ret_valid !== 1'b0 || ctx_busy !== 1'b0) begin errors++; $display("FAIL ret_after got sp=%0d valid=%b busy=%b exp 0 0 0", rf_stack_pointer, ctx_ret_valid, ctx_busy); end
    endtask

    task automatic test_nested_overflow();
        logic a, p, v; logic [4:0] s, pc;
        for (int i = 1; i <= 8; i++) begin
            do_call(5'(i), a, p, s);
            checks++; if (a !== 1'b1 || p !== 1'b1 || s !== 5'(i)) begin errors++; $display("FAIL nest_call%0d got ack=%b push=%b sp=%0d exp 1 1 %0d", i, a, p, s, i); end
        end
        do_call(5'h1F, a, p, s);
        checks++; if (a !== 1'b1 || p !== 1'b0 || s !== 5'd8) begin errors++; $display("FAIL ovf_call got ack=%b push=%b sp=%0d exp 1 0 8", a, p, s); end
        checks++; if (ctx_err_ovf !== 1'b1 || ctx_busy !== 1'b0) begin errors++; $display("FAIL ovf_flag got ovf=%b busy=%b exp 1 0", ctx_err_ovf, ctx_busy); end
        for (int i = 8; i >= 1; i--) begin
            do_ret(a, p, s, v, pc);
            checks++; if (p !== 1'b1 || s !== 5'(i) || v !== 1'b1 || pc !== 5'(i)) begin errors++; $display("FAIL lifo_ret%0d got pop=%b sp=%0d valid=%b pc=%0h exp 1 %0d 1 %0h", i, p, s, v, pc, i, i); end
        end
        @(negedge clk);
        ctx_err_clr = 1'b1;
        #1;
        checks++; if (rf_stack_pointer !== 5'd0 || ctx_err_ovf !== 1'b1) begin errors++; $display("FAIL nest_end got sp=%0d ovf=%b exp 0 1", rf_stack_pointer, ctx_err_ovf); end
        @(negedge clk);
        ctx_err_clr = 1'b0;
        #1;
        checks++; if (ctx_err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", ctx_err_ovf); end
    endtask

    task automatic test_underflow();
        logic a, p, v; logic [4:0] s, pc;
        do_ret(a, p, s, v, pc);
        checks++; if (a !== 1'b1 || p !== 1'b0 || v !== 1'b0 || s !== 5'd0) begin errors++; $display("FAIL unf_ret got ack=%b pop=%b valid=%b sp=%0d exp 1 0 0 0", a, p, v, s); end
        checks++; if (ctx_err_unf !== 1'b1 || rf_stack_pop !== 1'b0) begin errors++; $display("FAIL unf_flag got unf=%b pop=%b exp 1 0", ctx_err_unf, rf_stack_pop); end
        @(negedge clk);
        ctx_err_clr = 1'b1;
        @(negedge clk);
        ctx_err_clr = 1'b0;
        #1;
        checks++; if (ctx_err_unf !== 1'b0) begin errors++; $display("FAIL unf_clr got %b exp 0", ctx_err_unf); end
        // Clear and a fresh underflow in the same cycle: the set must win.
        @(negedge clk);
        ctx_ret_req = 1'b1; ctx_err_clr = 1'b1;
        @(negedge clk);
        ctx_ret_req = 1'b0; ctx_err_clr = 1'b0;
        #1;
        checks++; if (ctx_err_unf !== 1'b1 || rf_stack_pop !== 1'b0) begin errors++; $display("FAIL unf_set_wins got unf=%b pop=%b exp 1 0", ctx_err_unf, rf_stack_pop); end
        @(negedge clk);
        ctx_err_clr = 1'b1;
        @(negedge clk);
        ctx_err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic a, p; logic [4:0] s;
        do_call(5'h03, a, p, s);
        do_call(5'h07, a, p, s);
        checks++; if (s !== 5'd2) begin errors++; $display("FAIL b2b_setup got sp=%0d exp 2", s); end
        @(negedge clk);
        ctx_call_req = 1'b1; ctx_ret_req = 1'b1; ctx_ret_pc_in = 5'h15;
        #1;
        checks++; if (ctx_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack0 got %b exp 1", ctx_ack); end
        @(negedge clk);
        ctx_call_req = 1'b0;
        #1;
        checks++; if (rf_stack_push !== 1'b1 || rf_stack_pop !== 1'b0 || rf_stack_pointer !== 5'd3 || ctx_ack !== 1'b0) begin errors++; $display("FAIL b2b_callwins got push=%b pop=%b sp=%0d ack=%b exp 1 0 3 0", rf_stack_push, rf_stack_pop, rf_stack_pointer, ctx_ack); end
        @(negedge clk);
        #1;
        checks++; if (ctx_ack !== 1'b1 || ctx_busy !== 1'b0) begin errors++; $display("FAIL b2b_ret_ack got ack=%b busy=%b exp 1 0", ctx_ack, ctx_busy); end
        @(negedge clk);
        ctx_ret_req = 1'b0;
        #1;
        checks++; if (rf_stack_pop !== 1'b1 || rf_stack_pointer !== 5'd3 || rf_we_inhibit !== 1'b1) begin errors++; $display("FAIL b2b_pop got pop=%b sp=%0d inh=%b exp 1 3 1", rf_stack_pop, rf_stack_pointer, rf_we_inhibit); end
        @(negedge clk);
        #1;
        checks++; if (ctx_ret_valid !== 1'b1 || ctx_ret_pc_out !== 5'h15 || rf_stack_pop !== 1'b0 || rf_we_inhibit !== 1'b0) begin errors++; $display("FAIL b2b_valid got valid=%b pc=%0h pop=%b inh=%b exp 1 15 0 0", ctx_ret_valid, ctx_ret_pc_out, rf_stack_pop, rf_we_inhibit); end
        @(negedge clk);
        #1;
        checks++; if (rf_stack_pointer !== 5'd2 || ctx_ret_valid !== 1'b0 || ctx_busy !== 1'b0) begin errors++; $display("FAIL b2b_end got sp=%0d valid=%b busy=%b exp 2 0 0", rf_stack_pointer, ctx_ret_valid, ctx_busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_call();
        test_call_ret();
        test_nested_overflow();
        test_underflow();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
